// File: rtl/svv_alloc_ctrl.sv
// In-order allocation tracker: round-robin tag allocation, out-of-order completion, in-order retire, sequenced flush.
// Optional macro SVV_CMPL_ERR_EN adds cmpl_err_o, a pulse flagging completions to non-live tags.
module svv_alloc_ctrl #(
  parameter int DEPTH = 16,
  parameter int NREQ  = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             cmpl_valid_i,
  input  logic [TAG_W-1:0] cmpl_tag_i,
  output logic             retire_valid_o,
  output logic [TAG_W-1:0] retire_tag_o,
  input  logic             flush_i,
  output logic             flush_busy_o,
  output logic [TAG_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
`ifdef SVV_CMPL_ERR_EN
  ,
  output logic             cmpl_err_o
`endif
);

  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [RR_W-1:0]  rr_q, rr_d;
  logic             retire_valid_q, retire_valid_d;
  logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
  logic             cmpl_err_q, cmpl_err_d;

  logic             is_run, alloc_en, found;
  logic [NREQ-1:0]  gnt;
  logic [RR_W-1:0]  gnt_idx;
  int unsigned      idx;
  logic             do_alloc, do_retire, do_drain, do_pop, cmpl_hit;

  assign is_run   = (state_q == ST_RUN);
  assign alloc_en = is_run && (count_q < DEPTH_C);

  // Scan requesters starting at rr_q; the first asserted one wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (alloc_en) begin
      for (int i = 0; i < NREQ; i++) begin
        idx = (int'(rr_q) + i) % NREQ;
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          gnt[idx]     = 1'b1;
          gnt_idx      = RR_W'(idx);
        end
      end
    end
  end

  assign do_alloc  = found;
  assign cmpl_hit  = is_run && cmpl_valid_i && valid_q[cmpl_tag_i];
  assign do_retire = is_run && valid_q[head_q] && done_q[head_q];
  assign do_drain  = !is_run && (count_q != '0);
  assign do_pop    = do_retire || do_drain;

  always_comb begin
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    done_d         = done_q;
    rr_d           = rr_q;
    retire_valid_d = do_retire;
    retire_tag_d   = retire_tag_q;
    cmpl_err_d     = is_run && cmpl_valid_i && !valid_q[cmpl_tag_i];

    if (cmpl_hit) done_d[cmpl_tag_i] = 1'b1;

    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (do_retire) retire_tag_d = head_q;

    if (do_alloc) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + 1'b1;
      rr_d            = (gnt_idx == RR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end

    if (do_alloc && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_alloc && do_pop) count_d = count_q - 1'b1;

    // Leave FLUSH once the entry drained this cycle was the last one (or none remained).
    if (is_run) begin
      if (flush_i) state_d = ST_FLUSH;
    end else if (count_q <= (TAG_W+1)'(1)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      rr_q           <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      cmpl_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      rr_q           <= rr_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      cmpl_err_q     <= cmpl_err_d;
    end
  end

  assign gnt_o          = gnt;
  assign alloc_tag_o    = tail_q;
  assign retire_valid_o = retire_valid_q;
  assign retire_tag_o   = retire_tag_q;
  assign flush_busy_o   = (state_q == ST_FLUSH);
  assign count_o        = count_q;
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);

`ifdef SVV_CMPL_ERR_EN
  assign cmpl_err_o = cmpl_err_q;
`else
  logic unused_err;
  assign unused_err = cmpl_err_q;
`endif

endmodule

// File: tb/tb_svv_alloc_ctrl.sv
// Directed bench for svv_alloc_ctrl: a vector table for the main flow plus hand sequences
// for full/no-bypass, tag wrap with simultaneous alloc+retire, and mid-operation reset.
module tb_svv_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rsn = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [3:0] alloc_tag;
  logic       cv = 1'b0;
  logic [3:0] ct = '0;
  logic       rv;
  logic [3:0] rt;
  logic       fl = 1'b0;
  logic       busy;
  logic [4:0] cnt;
  logic       full, empty;
`ifdef SVV_CMPL_ERR_EN
  logic       err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  svv_alloc_ctrl #(.DEPTH(16), .NREQ(4), .TAG_W(4)) dut (
    .clk_i(clk), .rsn_i(rsn), .req_i(req), .gnt_o(gnt), .alloc_tag_o(alloc_tag),
    .cmpl_valid_i(cv), .cmpl_tag_i(ct), .retire_valid_o(rv), .retire_tag_o(rt),
    .flush_i(fl), .flush_busy_o(busy), .count_o(cnt), .full_o(full), .empty_o(empty)
`ifdef SVV_CMPL_ERR_EN
    , .cmpl_err_o(err)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic       cv;
    logic [3:0] ct;
    logic       fl;
    logic [3:0] gnt;
    logic [3:0] atag;
    logic       rv;
    logic [3:0] rt;
    int         cnt;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic c, input logic [3:0] t, input logic f,
                     input logic [3:0] g, input logic [3:0] at, input logic v, input logic [3:0] vt,
                     input int n, input logic b, input logic e);
    vec_t x;
    x.req = r; x.cv = c; x.ct = t; x.fl = f; x.gnt = g; x.atag = at;
    x.rv = v; x.rt = vt; x.cnt = n; x.busy = b; x.err = e;
    vecs.push_back(x);
  endtask

  // Inputs change on the falling edge; outputs sampled 2 time units later.
  task automatic drive(input logic [3:0] r, input logic c, input logic [3:0] t, input logic f);
    @(negedge clk);
    req = r; cv = c; ct = t; fl = f;
    #2;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rsn = 1'b0; req = '0; cv = 1'b0; ct = '0; fl = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
  endtask

  initial begin
    // req   cv ct  fl | gnt  atag rv rt   cnt busy err
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  0,  0,  0);  // 0 reset state
    add(4'hF, 0, 0, 0,   4'h1, 0,   0, 0,  0,  0,  0);  // 1
    add(4'hF, 0, 0, 0,   4'h2, 1,   0, 0,  1,  0,  0);  // 2
    add(4'hF, 0, 0, 0,   4'h4, 2,   0, 0,  2,  0,  0);  // 3
    add(4'hF, 0, 0, 0,   4'h8, 3,   0, 0,  3,  0,  0);  // 4
    add(4'h0, 1, 2, 0,   4'h0, 0,   0, 0,  4,  0,  0);  // 5 complete 2
    add(4'h0, 1, 1, 0,   4'h0, 0,   0, 0,  4,  0,  0);  // 6 complete 1
    add(4'h0, 1, 0, 0,   4'h0, 0,   0, 0,  4,  0,  0);  // 7 complete 0
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  4,  0,  0);  // 8
    add(4'h0, 0, 0, 0,   4'h0, 0,   1, 0,  3,  0,  0);  // 9 retire 0
    add(4'h0, 0, 0, 0,   4'h0, 0,   1, 1,  2,  0,  0);  // 10 retire 1
    add(4'h0, 0, 0, 0,   4'h0, 0,   1, 2,  1,  0,  0);  // 11 retire 2
    add(4'hA, 0, 0, 0,   4'h2, 4,   0, 0,  1,  0,  0);  // 12 rr from 0
    add(4'hA, 0, 0, 0,   4'h8, 5,   0, 0,  2,  0,  0);  // 13 rr from 2
    add(4'h4, 0, 0, 0,   4'h4, 6,   0, 0,  3,  0,  0);  // 14
    add(4'h3, 0, 0, 0,   4'h1, 7,   0, 0,  4,  0,  0);  // 15 rr wraps 3->0
    add(4'h0, 1, 10, 0,  4'h0, 0,   0, 0,  5,  0,  0);  // 16 invalid tag
    add(4'h0, 1, 4, 1,   4'h0, 0,   0, 0,  5,  0,  1);  // 17 flush + complete
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  5,  1,  0);  // 18 FLUSH
    add(4'hF, 1, 5, 1,   4'h0, 0,   0, 0,  4,  1,  0);  // 19 no grant in FLUSH
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  3,  1,  0);  // 20
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  2,  1,  0);  // 21
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  1,  1,  0);  // 22
    add(4'h1, 0, 0, 0,   4'h1, 8,   0, 0,  0,  0,  0);  // 23 tag = old head 3 + 5
    add(4'h0, 1, 8, 0,   4'h0, 0,   0, 0,  1,  0,  0);  // 24
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  1,  0,  0);  // 25
    add(4'h0, 0, 0, 0,   4'h0, 0,   1, 8,  0,  0,  0);  // 26
    add(4'h0, 0, 0, 1,   4'h0, 0,   0, 0,  0,  0,  0);  // 27 flush on empty
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  0,  1,  0);  // 28 exactly one FLUSH cycle
    add(4'h2, 0, 0, 0,   4'h2, 9,   0, 0,  0,  0,  0);  // 29
    add(4'h0, 0, 0, 0,   4'h0, 0,   0, 0,  1,  0,  0);  // 30

    reset_dut();
    #2;
    check("rst_rt", 32'(rt), 32'd0);

    foreach (vecs[k]) begin
      drive(vecs[k].req, vecs[k].cv, vecs[k].ct, vecs[k].fl);
      $display("[TB] row %0d req=%b gnt=%b tag=%0d rv=%b rt=%0d cnt=%0d busy=%b",
               k, req, gnt, alloc_tag, rv, rt, cnt, busy);
      check($sformatf("row%0d_gnt", k), 32'(gnt), 32'(vecs[k].gnt));
      if (vecs[k].gnt != 0) check($sformatf("row%0d_tag", k), 32'(alloc_tag), 32'(vecs[k].atag));
      check($sformatf("row%0d_rv", k), 32'(rv), 32'(vecs[k].rv));
      if (vecs[k].rv) check($sformatf("row%0d_rt", k), 32'(rt), 32'(vecs[k].rt));
      check($sformatf("row%0d_cnt", k), 32'(cnt), 32'(vecs[k].cnt));
      check($sformatf("row%0d_full", k), 32'(full), 32'(vecs[k].cnt == 16));
      check($sformatf("row%0d_empty", k), 32'(empty), 32'(vecs[k].cnt == 0));
      check($sformatf("row%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
`ifdef SVV_CMPL_ERR_EN
      check($sformatf("row%0d_err", k), 32'(err), 32'(vecs[k].err));
`endif
    end

    // Fill to DEPTH, then check full blocks allocation even with a same-cycle retire.
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      drive(4'hF, 1'b0, 4'h0, 1'b0);
      $display("[TB] fill %0d gnt=%b tag=%0d cnt=%0d", i, gnt, alloc_tag, cnt);
      check($sformatf("fill%0d_gnt", i), 32'(gnt), 32'(1 << (i % 4)));
      check($sformatf("fill%0d_tag", i), 32'(alloc_tag), 32'(i));
      check($sformatf("fill%0d_cnt", i), 32'(cnt), 32'(i));
    end
    drive(4'hF, 1'b1, 4'h0, 1'b0);
    $display("[TB] full gnt=%b cnt=%0d full=%b", gnt, cnt, full);
    check("full_gnt", 32'(gnt), 32'd0);
    check("full_flag", 32'(full), 32'd1);
    check("full_cnt", 32'(cnt), 32'd16);
    drive(4'hF, 1'b0, 4'h0, 1'b0);
    $display("[TB] full+1 gnt=%b rv=%b full=%b", gnt, rv, full);
    check("nobypass_gnt", 32'(gnt), 32'd0);
    check("nobypass_full", 32'(full), 32'd1);
    check("nobypass_rv", 32'(rv), 32'd0);
    drive(4'h0, 1'b0, 4'h0, 1'b0);
    $display("[TB] full+2 rv=%b rt=%0d full=%b cnt=%0d", rv, rt, full, cnt);
    check("n2_rv", 32'(rv), 32'd1);
    check("n2_rt", 32'(rt), 32'd0);
    check("n2_full", 32'(full), 32'd0);
    check("n2_cnt", 32'(cnt), 32'd15);

    // Tag wrap: one entry in flight, retire and allocate in the same cycle.
    reset_dut();
    drive(4'h1, 1'b0, 4'h0, 1'b0);
    check("wrap_first_gnt", 32'(gnt), 32'd1);
    check("wrap_first_tag", 32'(alloc_tag), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(4'h0, 1'b1, 4'(i % 16), 1'b0);
      $display("[TB] wrap %0d cmpl=%0d rv=%b rt=%0d cnt=%0d", i, ct, rv, rt, cnt);
      check($sformatf("wrapA%0d_cnt", i), 32'(cnt), 32'd1);
      check($sformatf("wrapA%0d_rv", i), 32'(rv), 32'(i > 0));
      if (i > 0) check($sformatf("wrapA%0d_rt", i), 32'(rt), 32'((i - 1) % 16));
      drive(4'h1, 1'b0, 4'h0, 1'b0);
      $display("[TB] wrap %0d gnt=%b tag=%0d cnt=%0d", i, gnt, alloc_tag, cnt);
      check($sformatf("wrapB%0d_gnt", i), 32'(gnt), 32'd1);
      check($sformatf("wrapB%0d_tag", i), 32'(alloc_tag), 32'((i + 1) % 16));
      check($sformatf("wrapB%0d_cnt", i), 32'(cnt), 32'd1);
      check($sformatf("wrapB%0d_rv", i), 32'(rv), 32'd0);
    end
    drive(4'h0, 1'b0, 4'h0, 1'b0);
    check("wrap_last_rv", 32'(rv), 32'd1);
    check("wrap_last_rt", 32'(rt), 32'd3);

    // Asynchronous reset mid-operation with one live entry (tag 4).
    #1 rsn = 1'b0;
    #1;
    $display("[TB] async reset cnt=%0d empty=%b rv=%b", cnt, empty, rv);
    check("arst_cnt", 32'(cnt), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_rv", 32'(rv), 32'd0);
    @(negedge clk);
    rsn = 1'b1;
    drive(4'h0, 1'b1, 4'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 1'b0, 4'h0, 1'b0);
      $display("[TB] post-reset %0d rv=%b cnt=%0d", i, rv, cnt);
      check($sformatf("post_rst%0d_rv", i), 32'(rv), 32'd0);
      check($sformatf("post_rst%0d_cnt", i), 32'(cnt), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svv_alloc_ctrl.md
Name: svv_alloc_ctrl

Overview:
- Controller that sequences an in-order status tracker of DEPTH entries shared between NREQ requesters.
- Round-robin arbitrates allocation (push) requests and hands out wrap-around tags.
- Accepts out-of-order completion updates by tag, and retires (pulls) entries strictly in allocation order.
- Provides a sequenced flush that drains all live entries one per cycle.

Parameters:
- DEPTH, 16, number of tracked entries; power of two, >= 2.
- NREQ, 4, number of allocation requesters; >= 2.
- TAG_W, 4, tag width; must equal log2(DEPTH).

Ports:
- clk_i  input  1  clock.
- rsn_i  input  1  reset, asynchronous, active-low.
- req_i  input  NREQ  per-requester allocation request; level, held until granted.
- gnt_o  output  NREQ  one-hot grant; combinational from req_i and state. Allocation happens at the edge ending the cycle.
- alloc_tag_o  output  TAG_W  tag given to the granted requester; meaningful only when |gnt_o.
- cmpl_valid_i  input  1  completion update strobe.
- cmpl_tag_i  input  TAG_W  tag being completed.
- retire_valid_o  output  1  registered pulse; oldest entry retired.
- retire_tag_o  output  TAG_W  tag retired; valid with retire_valid_o.
- flush_i  input  1  start flush; single-cycle pulse.
- flush_busy_o  output  1  high while FLUSH state is active.
- count_o  output  TAG_W+1  live entry count.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset state:
  - head = tail = 0, count = 0.
  - valid and done vectors cleared.
  - rr_ptr = 0, FSM = RUN.
  - retire_valid_o = 0, retire_tag_o = 0.
  - flush_busy_o = 0, empty_o = 1, full_o = 0.
- Reset asserted mid-operation discards all entries; nothing is retired.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on flush_i.
  - FLUSH -> RUN in the cycle after count reaches 0.
- Allocation:
  - Enabled only in RUN with count < DEPTH. No bypass: full blocks allocation even if a retire occurs the same cycle.
  - Grant goes to the first asserted req_i at or after rr_ptr, wrapping modulo NREQ.
  - On grant: valid[tail] = 1, done[tail] = 0, alloc_tag_o = tail, tail = (tail+1) mod DEPTH. rr_ptr becomes (granted index + 1) mod NREQ.
  - At most one grant per cycle. gnt_o = 0 when disabled.
- Completion:
  - In RUN, when cmpl_valid_i is high and valid[cmpl_tag_i] is set, done[cmpl_tag_i] is set at the edge.
  - Completion to an invalid tag is ignored. Completion to an already-done entry is idempotent.
  - Completions are ignored in FLUSH.
- Retire:
  - In RUN, when valid[head] and done[head]: clear valid[head] and done[head], head++, retire_valid_o = 1 and retire_tag_o = head on the next cycle.
  - At most one retire per cycle.
  - Latency: completion of the head tag in cycle N gives retire_valid_o in cycle N+2.
- Count:
  - +1 on alloc, -1 on retire or flush-drain; unchanged when both occur.
  - Head and tail wrap modulo DEPTH.
- Flush:
  - flush_i is sampled in RUN only; the allocation and completion in that same cycle are still performed.
  - In FLUSH, each cycle with count > 0 clears valid[head] and done[head], head++, count--. No retire pulses are issued.
  - flush_busy_o = 1 for every FLUSH cycle.
  - Flush on empty: exactly one FLUSH cycle.
  - flush_i during FLUSH is ignored.
  - Done bits of drained entries are discarded.

Optional Feature:
- Macro SVV_CMPL_ERR_EN.
- When defined: adds output cmpl_err_o (1 bit), a registered pulse one cycle after cmpl_valid_i targets an invalid tag in RUN. Reset value 0.
- When undefined: the port is absent and invalid completions are silently ignored.

Test Plan:
- Reset then req_i=4'b1111 held for 4 cycles -> grants 0001, 0010, 0100, 1000 with tags 0,1,2,3; count_o=4.
- Allocate 16 entries -> full_o=1, gnt_o=0 with req_i high. Complete tag 0 in cycle N -> retire_valid_o, retire_tag_o=0 in N+2, full_o=0 in N+2.
- Complete tags 2, 1, 0 in order with tags 0-2 live -> retire pulses on three consecutive cycles, tags 0, 1, 2.
- Tail wrap: 20 alloc/retire pairs -> tags wrap 15->0; count stays at or below DEPTH; alloc and retire in the same cycle leave count unchanged.
- 5 live entries, flush_i pulse -> flush_busy_o high 5 cycles, no retire pulses; then RUN with count_o=0 and empty_o=1. The next grant gets tag = old head + 5.
- With SVV_CMPL_ERR_EN: completion to a non-live tag -> cmpl_err_o pulse next cycle; done vector unchanged.
